// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA decryptor slice.
// Contents: operand/product widths, decryptor FSM state encoding,
// per-bit latency constants, and the single-step restoring remainder helper.
package rsa_pkg;

    localparam int W            = 6;   // operand width
    localparam int PW           = 12;  // product width (2*W)
    localparam int MODMUL_CYC   = 13;  // issue cycle + 12 reduction cycles
    localparam int BIT_BASE_CYC = 14;  // square + NEXT per exponent bit

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SQR   = 3'd1,
        SQR_W = 3'd2,
        MUL   = 3'd3,
        MUL_W = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6
    } state_t;

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder, subtract the modulus if it fits. The partial
    // remainder is kept one bit wider than W so the shifted value never
    // overflows before the compare.
    function automatic logic [W:0] reduce_step(
        input logic [W:0]   rem,
        input logic         din,
        input logic [W-1:0] modulus
    );
        logic [W+1:0] shifted;
        logic [W:0]   diff;
        shifted = {rem, din};
        diff    = shifted[W:0] - {1'b0, modulus};
        if (shifted >= {2'b00, modulus}) begin
            reduce_step = diff;
        end else begin
            reduce_step = shifted[W:0];
        end
    endfunction

endpackage

// File: rtl/rsa_decrypt_mod_reduce.sv
// Restoring remainder engine: rem = dividend mod modulus.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   go            - start a reduction (ignored while one is running)
//   dividend[11:0], modulus[5:0] - operands, sampled on accepted go
//   rem[5:0]      - remainder, valid while rvalid is high
//   rvalid        - one-cycle pulse, 12 cycles after the go cycle
// The first dividend bit is consumed on the go edge itself, the remaining
// eleven on the following edges, which puts rvalid exactly 12 cycles after
// the issue cycle.
module mod_reduce
    import rsa_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [PW-1:0] dividend,
    input  logic [W-1:0]  modulus,
    output logic [W-1:0]  rem,
    output logic          rvalid
);

    logic [W:0]    rem_r;
    logic [PW-1:0] shift_r;
    logic [W-1:0]  mod_r;
    logic [3:0]    cnt_r;
    logic          running_r;
    logic          rvalid_r;

    // Bit-serial restoring reduction, MSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r     <= '0;
            shift_r   <= '0;
            mod_r     <= '0;
            cnt_r     <= 4'd0;
            running_r <= 1'b0;
            rvalid_r  <= 1'b0;
        end else begin
            rvalid_r <= 1'b0;
            if (running_r) begin
                rem_r   <= reduce_step(rem_r, shift_r[PW-1], mod_r);
                shift_r <= {shift_r[PW-2:0], 1'b0};
                cnt_r   <= cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    running_r <= 1'b0;
                    rvalid_r  <= 1'b1;
                end
            end else if (go) begin
                mod_r     <= modulus;
                rem_r     <= reduce_step({(W+1){1'b0}}, dividend[PW-1], modulus);
                shift_r   <= {dividend[PW-2:0], 1'b0};
                cnt_r     <= 4'd11;
                running_r <= 1'b1;
            end
        end
    end

    assign rem    = rem_r[W-1:0];
    assign rvalid = rvalid_r;

endmodule

// File: rtl/rsa_decrypt.sv
// Sequential RSA decryptor: plain = cipher^key_d mod N (6-bit operands),
// left-to-right square-and-multiply over all six exponent bits.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   start                 - one-cycle request, sampled only in IDLE
//   cipher, N, key_d      - operands, captured on accepted start
//   plain                 - result, held until the next accepted start
//   done                  - one-cycle pulse when plain/err are valid
//   busy                  - high from the cycle after accept through done
//   err                   - N<2 or cipher>=N; valid with done
module rsa_decrypt
    import rsa_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] cipher,
    input  logic [W-1:0] N,
    input  logic [W-1:0] key_d,
    output logic [W-1:0] plain,
    output logic         done,
    output logic         busy,
    output logic         err
);

    state_t        state_r;
    logic [W-1:0]  cipher_r;
    logic [W-1:0]  n_r;
    logic [W-1:0]  key_r;
    logic [W-1:0]  acc_r;
    logic [2:0]    idx_r;
    logic [W-1:0]  plain_r;
    logic          done_r;
    logic          busy_r;
    logic          err_r;

    logic          red_go_s;
    logic [PW-1:0] red_dividend_s;
    logic [W-1:0]  red_rem_s;
    logic          red_valid_s;

    // Reducer request: issue the square or multiply product in the issue states.
    always_comb begin
        red_go_s       = 1'b0;
        red_dividend_s = '0;
        case (state_r)
            SQR: begin
                red_go_s       = 1'b1;
                red_dividend_s = {6'd0, acc_r} * {6'd0, acc_r};
            end
            MUL: begin
                red_go_s       = 1'b1;
                red_dividend_s = {6'd0, acc_r} * {6'd0, cipher_r};
            end
            default: begin
                red_go_s       = 1'b0;
                red_dividend_s = '0;
            end
        endcase
    end

    mod_reduce u_mod_reduce (
        .clk      (clk),
        .rst      (rst),
        .go       (red_go_s),
        .dividend (red_dividend_s),
        .modulus  (n_r),
        .rem      (red_rem_s),
        .rvalid   (red_valid_s)
    );

    // Control FSM with registered outputs. Leading zero exponent bits are
    // still squared so that latency depends only on the exponent popcount.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cipher_r <= '0;
            n_r      <= '0;
            key_r    <= '0;
            acc_r    <= '0;
            idx_r    <= 3'd0;
            plain_r  <= '0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        cipher_r <= cipher;
                        n_r      <= N;
                        key_r    <= key_d;
                        acc_r    <= 6'd1;
                        idx_r    <= 3'd5;
                        busy_r   <= 1'b1;
                        if ((N < 6'd2) || (cipher >= N)) begin
                            err_r   <= 1'b1;
                            plain_r <= '0;
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            err_r   <= 1'b0;
                            state_r <= SQR;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SQR: begin
                    state_r <= SQR_W;
                end
                SQR_W: begin
                    if (red_valid_s) begin
                        acc_r   <= red_rem_s;
                        state_r <= key_r[idx_r] ? MUL : NEXT;
                    end else begin
                        state_r <= SQR_W;
                    end
                end
                MUL: begin
                    state_r <= MUL_W;
                end
                MUL_W: begin
                    if (red_valid_s) begin
                        acc_r   <= red_rem_s;
                        state_r <= NEXT;
                    end else begin
                        state_r <= MUL_W;
                    end
                end
                NEXT: begin
                    if (idx_r == 3'd0) begin
                        plain_r <= acc_r;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        idx_r   <= idx_r - 3'd1;
                        state_r <= SQR;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign plain = plain_r;
    assign done  = done_r;
    assign busy  = busy_r;
    assign err   = err_r;

endmodule

// File: tb/tb_rsa_decrypt.sv
// Directed self-checking bench for rsa_decrypt: hand-computed results and
// latencies (85 + 13*popcount(key_d), or 1 cycle for rejected operands).
module tb_rsa_decrypt;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] cipher;
    logic [5:0] N;
    logic [5:0] key_d;
    logic [5:0] plain;
    logic       done;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    rsa_decrypt dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cipher (cipher),
        .N      (N),
        .key_d  (key_d),
        .plain  (plain),
        .done   (done),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one request and watch it to completion. restart_at>0 pulses a
    // second start (with different operands) at that cycle of the run.
    task automatic run_op(input string tag, input logic [5:0] c, input logic [5:0] n,
                          input logic [5:0] d, input logic [5:0] exp_plain,
                          input logic exp_err, input int exp_lat, input int restart_at);
        int done_at;
        int done_cnt;
        int busy_low;
        logic [5:0] got_plain;
        logic got_err;
        logic busy_after;
        done_at = -1; done_cnt = 0; busy_low = 0;
        got_plain = 6'd0; got_err = 1'b0; busy_after = 1'b1;
        cipher = c; N = n; key_d = d; start = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            if ((restart_at > 0) && (k == restart_at)) begin
                start = 1'b1; cipher = 6'd2; N = 6'd7; key_d = 6'd1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k; got_plain = plain; got_err = err;
                end
            end
            if ((done_at < 0) && !busy) busy_low++;
            if ((done_at > 0) && (k == done_at + 1)) busy_after = busy;
            if ((done_at > 0) && (k >= done_at + 3)) break;
        end
        check_val({tag, " latency"}, done_at, exp_lat);
        check_val({tag, " done_pulses"}, done_cnt, 1);
        check_val({tag, " busy_low_cycles"}, busy_low, 0);
        check_val({tag, " plain"}, got_plain, exp_plain);
        check_val({tag, " err"}, got_err, exp_err);
        check_val({tag, " busy_after_done"}, busy_after, 1'b0);
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; start = 1'b0; cipher = 6'd0; N = 6'd0; key_d = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset plain", plain, 6'd0);
        check_val("reset done", done, 1'b0);
        check_val("reset busy", busy, 1'b0);
        check_val("reset err", err, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("c31n33d7", 6'd31, 6'd33, 6'd7, 6'd4, 1'b0, 124, 0);
        run_op("c8n55d27", 6'd8, 6'd55, 6'd27, 6'd2, 1'b0, 137, 0);
        run_op("c5n33d0", 6'd5, 6'd33, 6'd0, 6'd1, 1'b0, 85, 0);
        run_op("c55n21_err", 6'd55, 6'd21, 6'd15, 6'd0, 1'b1, 1, 0);
        run_op("n1_err", 6'd0, 6'd1, 6'd3, 6'd0, 1'b1, 1, 0);
        run_op("n0_err", 6'd0, 6'd0, 6'd3, 6'd0, 1'b1, 1, 0);
        run_op("c3n5d3", 6'd3, 6'd5, 6'd3, 6'd2, 1'b0, 111, 0);
        run_op("restart_ignored", 6'd31, 6'd33, 6'd7, 6'd4, 1'b0, 124, 10);

        // Abort a run with reset at cycle 40, then confirm a clean rerun.
        cipher = 6'd31; N = 6'd33; key_d = 6'd7; start = 1'b1;
        done_seen = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) done_seen++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("abort plain", plain, 6'd0);
        check_val("abort busy", busy, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check_val("abort no_done", done_seen, 0);
        run_op("after_abort", 6'd31, 6'd33, 6'd7, 6'd4, 1'b0, 124, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
